// File: rtl/complex_pkg.sv
// Shared types and index constants for the sequential complex multiplier.
package complex_pkg;

    localparam int unsigned FP_W     = 64;
    localparam int unsigned NUM_OPS  = 6;
    localparam int unsigned MUL_OPS  = 4;
    localparam int unsigned CNT_W    = 3;

    // operand vector positions
    localparam int unsigned AR_IDX   = 3;
    localparam int unsigned AI_IDX   = 2;
    localparam int unsigned BR_IDX   = 1;
    localparam int unsigned BI_IDX   = 0;

    // result and FPU operand positions
    localparam int unsigned RE_IDX   = 1;
    localparam int unsigned IM_IDX   = 0;
    localparam int unsigned X_IDX    = 1;
    localparam int unsigned Y_IDX    = 0;

    // response slots, written in issue order
    localparam int unsigned P0_SLOT  = 0;
    localparam int unsigned P1_SLOT  = 1;
    localparam int unsigned P2_SLOT  = 2;
    localparam int unsigned P3_SLOT  = 3;
    localparam int unsigned RE_SLOT  = 4;
    localparam int unsigned IM_SLOT  = 5;

    // responses needed before the final subtract/add may issue
    localparam int unsigned SUB_NEED = 2;
    localparam int unsigned ADD_NEED = 4;

    typedef enum logic [1:0] {
        COP_MUL = 2'd0,
        COP_ADD = 2'd1,
        COP_SUB = 2'd2
    } cop_e;

endpackage

// File: rtl/fpnew_pkg.sv
// FPU status flag type shared with the floating-point unit.
// Bit order matches the FPU: {nv, dz, of, uf, nx}, nx in bit 0.
package fpnew_pkg;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

endpackage

// File: rtl/complex_mul_seq_if.sv
// Job-side bundle of the complex multiplier: operand input, result output, control.
interface complex_mul_seq_if;
    import complex_pkg::*;

    logic [3:0][FP_W-1:0] operands;
    logic                 in_valid;
    logic                 in_ready;
    logic                 flush;
    logic [1:0][FP_W-1:0] result;
    fpnew_pkg::status_t   status;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;

    modport master (
        output operands, in_valid, flush, out_ready,
        input  in_ready, result, status, out_valid, busy
    );

    modport slave (
        input  operands, in_valid, flush, out_ready,
        output in_ready, result, status, out_valid, busy
    );

endinterface

// File: rtl/complex_mul_seq.sv
// Sequential FP64 complex multiply (a*b) built from six ops on an external in-order FPU.
// The block only sequences operations and copies bits; all arithmetic happens in the FPU.
module complex_mul_seq
    import complex_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [3:0][FP_W-1:0] operands_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    output logic [1:0][FP_W-1:0] result_o,
    output fpnew_pkg::status_t   status_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o,
    output logic                 fpu_req_valid_o,
    input  logic                 fpu_req_ready_i,
    output cop_e                 fpu_op_o,
    output logic [1:0][FP_W-1:0] fpu_operands_o,
    output logic                 fpu_flush_o,
    input  logic                 fpu_rsp_valid_i,
    output logic                 fpu_rsp_ready_o,
    input  logic [FP_W-1:0]      fpu_result_i,
    input  fpnew_pkg::status_t   fpu_status_i
);

    localparam int unsigned ST_W = $bits(fpnew_pkg::status_t);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                     state;
    state_e                     state_next;
    logic [3:0][FP_W-1:0]       ops;
    logic [NUM_OPS-1:0][FP_W-1:0] slot;
    fpnew_pkg::status_t         status;
    logic [CNT_W-1:0]           iss_cnt;
    logic [CNT_W-1:0]           rsp_cnt;
    logic                       in_hs;
    logic                       req_hs;
    logic                       rsp_hs;
    logic                       last_rsp;
    logic                       op_ready;

    assign in_ready_o      = (state == IDLE);
    assign busy_o          = (state != IDLE);
    assign out_valid_o     = (state == DONE);
    assign result_o        = {slot[RE_SLOT], slot[IM_SLOT]};
    assign status_o        = status;
    assign fpu_flush_o     = flush_i;
    assign fpu_rsp_ready_o = (state == RUN) && !flush_i;
    assign fpu_req_valid_o = (state == RUN) && !flush_i && op_ready;

    assign in_hs    = in_valid_i && in_ready_o;
    assign req_hs   = fpu_req_valid_o && fpu_req_ready_i;
    assign rsp_hs   = fpu_rsp_valid_i && fpu_rsp_ready_o;
    assign last_rsp = rsp_hs && (rsp_cnt == CNT_W'(NUM_OPS - 1));

    // Products issue freely; sub/add wait for the responses they consume.
    always_comb begin
        op_ready = 1'b0;
        if (iss_cnt < CNT_W'(MUL_OPS))
            op_ready = 1'b1;
        else if (iss_cnt == CNT_W'(RE_SLOT))
            op_ready = (rsp_cnt >= CNT_W'(SUB_NEED));
        else if (iss_cnt == CNT_W'(IM_SLOT))
            op_ready = (rsp_cnt >= CNT_W'(ADD_NEED));
    end

    // Operation select: fixed issue order indexed by iss_cnt.
    always_comb begin
        fpu_op_o       = COP_MUL;
        fpu_operands_o = '0;
        case (iss_cnt)
            3'd0: begin
                fpu_operands_o[X_IDX] = ops[AR_IDX];
                fpu_operands_o[Y_IDX] = ops[BR_IDX];
            end
            3'd1: begin
                fpu_operands_o[X_IDX] = ops[AI_IDX];
                fpu_operands_o[Y_IDX] = ops[BI_IDX];
            end
            3'd2: begin
                fpu_operands_o[X_IDX] = ops[AR_IDX];
                fpu_operands_o[Y_IDX] = ops[BI_IDX];
            end
            3'd3: begin
                fpu_operands_o[X_IDX] = ops[AI_IDX];
                fpu_operands_o[Y_IDX] = ops[BR_IDX];
            end
            3'd4: begin
                fpu_op_o              = COP_SUB;
                fpu_operands_o[X_IDX] = slot[P0_SLOT];
                fpu_operands_o[Y_IDX] = slot[P1_SLOT];
            end
            3'd5: begin
                fpu_op_o              = COP_ADD;
                fpu_operands_o[X_IDX] = slot[P2_SLOT];
                fpu_operands_o[Y_IDX] = slot[P3_SLOT];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    // DONE is entered in the same cycle the sixth response lands.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_hs)       state_next = RUN;
            RUN:     if (last_rsp)    state_next = DONE;
            DONE:    if (out_ready_i) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
        if (flush_i) state_next = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ops     <= '0;
            slot    <= '0;
            status  <= '0;
            iss_cnt <= '0;
            rsp_cnt <= '0;
        end else if (flush_i) begin
            iss_cnt <= '0;
            rsp_cnt <= '0;
        end else begin
            if (in_hs) begin
                ops     <= operands_i;
                status  <= '0;
                iss_cnt <= '0;
                rsp_cnt <= '0;
            end
            if (req_hs) iss_cnt <= iss_cnt + CNT_W'(1);
            if (rsp_hs) begin
                slot[rsp_cnt] <= fpu_result_i;
                status        <= fpnew_pkg::status_t'(ST_W'(status) | ST_W'(fpu_status_i));
                rsp_cnt       <= rsp_cnt + CNT_W'(1);
            end
        end
    end

    // The FPU must never answer more operations than were issued.
    excess_rsp_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(fpu_rsp_valid_i && state == RUN && rsp_cnt >= CNT_W'(NUM_OPS)));

endmodule
